// File: rtl/gic_core_if.sv
// Interrupt request, claim and end-of-interrupt signals between the CPU side and gic_core.
// gic_core connects through the slave modport; the CPU side or a bench connects through the master modport.
interface gic_core_if #(
  parameter int N    = 10,
  parameter int ID_W = $clog2(N)
);
  logic [N-1:0]    int_in;
  logic [N-1:0]    int_en;
  logic [N-1:0]    int_edge;
  logic            int_out;
  logic            int_ack;
  logic [ID_W-1:0] int_id;
  logic            int_id_vld;
  logic            int_eoi;
  logic [N-1:0]    pending;

  modport master (
    output int_in, int_en, int_edge, int_ack, int_eoi,
    input  int_out, int_id, int_id_vld, pending
  );

  modport slave (
    input  int_in, int_en, int_edge, int_ack, int_eoi,
    output int_out, int_id, int_id_vld, pending
  );
endinterface

// File: rtl/gic_core.sv
// Fixed-priority interrupt controller with one-cycle request latency, per-source enable and edge/level trigger.
// There is no backpressure: the CPU paces service through ack/EOI, and new requests stay latched until they are served.
module gic_core #(
  parameter int N    = 10,
  parameter int ID_W = $clog2(N)
) (
  input  logic       clk,
  input  logic       rst,
  gic_core_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t          state, state_d;
  logic [N-1:0]    int_in_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    pend_base, qual, rise, claim_sel;
  logic            int_out_q, int_out_d;
  logic            id_vld_q, id_vld_d;
  logic [ID_W-1:0] id_q, id_d, low_idx;
  logic            any_qual, claim;

  assign rise = bus.int_in & ~int_in_q;

  // Pending value before any claim clear. Arbitration and FSM decisions use this value.
  assign pend_base = (bus.int_edge & (pending_q | rise)) | (~bus.int_edge & bus.int_in);
  assign qual      = pend_base & bus.int_en;
  assign any_qual  = |qual;
  assign claim_sel = qual & (~qual + {{(N-1){1'b0}}, 1'b1});

  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (qual[i]) low_idx = ID_W'(i);
    end
  end

  // A rise on the claimed edge source in the same cycle sets the bit again, so the set wins.
  always_comb begin
    pending_d = (bus.int_edge & (rise | (pending_q & ~(claim ? claim_sel : '0))))
              | (~bus.int_edge & bus.int_in);
  end

  always_comb begin
    state_d   = state;
    int_out_d = int_out_q;
    id_vld_d  = id_vld_q;
    id_d      = id_q;
    claim     = 1'b0;
    case (state)
      IDLE: begin
        if (any_qual) begin
          state_d   = ASSERT;
          int_out_d = 1'b1;
        end
      end
      ASSERT: begin
        if (!any_qual) begin
          state_d   = IDLE;
          int_out_d = 1'b0;
        end else if (bus.int_ack) begin
          claim     = 1'b1;
          id_d      = low_idx;
          id_vld_d  = 1'b1;
          int_out_d = 1'b0;
          state_d   = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.int_eoi) begin
          state_d  = IDLE;
          id_vld_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        int_out_d = 1'b0;
        id_vld_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      int_in_q  <= '0;
      pending_q <= '0;
      int_out_q <= 1'b0;
      id_vld_q  <= 1'b0;
      id_q      <= '0;
    end else begin
      state     <= state_d;
      int_in_q  <= bus.int_in;
      pending_q <= pending_d;
      int_out_q <= int_out_d;
      id_vld_q  <= id_vld_d;
      id_q      <= id_d;
    end
  end

  assign bus.int_out    = int_out_q;
  assign bus.int_id_vld = id_vld_q;
  assign bus.int_id     = id_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_gic_core.sv
// Per-cycle vector table for gic_core, with expected results queued as a scoreboard, plus an async reset sequence.
module tb_gic_core;

  localparam int N    = 10;
  localparam int ID_W = 4;
  localparam int NV   = 34;

  typedef struct {
    logic [N-1:0]    din;
    logic [N-1:0]    en;
    logic [N-1:0]    edg;
    logic            ack;
    logic            eoi;
    logic            xout;
    logic            xvld;
    logic [ID_W-1:0] xid;
    logic [N-1:0]    xpend;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vec_t tv [NV];
  vec_t expq [$];

  gic_core_if #(.N(N)) bus ();

  gic_core #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [N-1:0] din, input logic [N-1:0] en,
                              input logic [N-1:0] edg, input logic ack, input logic eoi,
                              input logic xout, input logic xvld, input logic [ID_W-1:0] xid,
                              input logic [N-1:0] xpend);
    vec_t v;
    v.din = din; v.en = en; v.edg = edg; v.ack = ack; v.eoi = eoi;
    v.xout = xout; v.xvld = xvld; v.xid = xid; v.xpend = xpend;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.int_in   = v.din;
    bus.int_en   = v.en;
    bus.int_edge = v.edg;
    bus.int_ack  = v.ack;
    bus.int_eoi  = v.eoi;
    expq.push_back(v);
  endtask

  task automatic compare(input int idx);
    vec_t e;
    if (expq.size() == 0) begin
      chk("scoreboard_empty", idx, 32'd1, 32'd0);
    end else begin
      e = expq.pop_front();
      chk("int_out", idx, 32'(bus.int_out), 32'(e.xout));
      chk("int_id_vld", idx, 32'(bus.int_id_vld), 32'(e.xvld));
      chk("int_id", idx, 32'(bus.int_id), 32'(e.xid));
      chk("pending", idx, 32'(bus.pending), 32'(e.xpend));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.int_in = '0; bus.int_en = '0; bus.int_edge = '0;
    bus.int_ack = 1'b0; bus.int_eoi = 1'b0;

    //          din     en      edg     ack eoi out vld id pend
    tv[0]  = mk(10'h008, 10'h3FF, 10'h000, 0, 0, 1, 0, 0, 10'h008);
    tv[1]  = mk(10'h008, 10'h3FF, 10'h000, 0, 0, 1, 0, 0, 10'h008);
    tv[2]  = mk(10'h008, 10'h3FF, 10'h000, 1, 0, 0, 1, 3, 10'h008);
    tv[3]  = mk(10'h008, 10'h3FF, 10'h000, 1, 0, 0, 1, 3, 10'h008);
    tv[4]  = mk(10'h008, 10'h3FF, 10'h000, 0, 1, 0, 0, 3, 10'h008);
    tv[5]  = mk(10'h008, 10'h3FF, 10'h000, 0, 0, 1, 0, 3, 10'h008);
    tv[6]  = mk(10'h000, 10'h3FF, 10'h000, 0, 0, 0, 0, 3, 10'h000);
    tv[7]  = mk(10'h000, 10'h3FF, 10'h000, 0, 0, 0, 0, 3, 10'h000);
    tv[8]  = mk(10'h084, 10'h3FF, 10'h3FF, 0, 0, 1, 0, 3, 10'h084);
    tv[9]  = mk(10'h084, 10'h3FF, 10'h3FF, 1, 0, 0, 1, 2, 10'h080);
    tv[10] = mk(10'h000, 10'h3FF, 10'h3FF, 0, 1, 0, 0, 2, 10'h080);
    tv[11] = mk(10'h000, 10'h3FF, 10'h3FF, 0, 0, 1, 0, 2, 10'h080);
    tv[12] = mk(10'h000, 10'h3FF, 10'h3FF, 1, 0, 0, 1, 7, 10'h000);
    tv[13] = mk(10'h000, 10'h3FF, 10'h3FF, 0, 1, 0, 0, 7, 10'h000);
    tv[14] = mk(10'h010, 10'h3FF, 10'h3FF, 0, 0, 1, 0, 7, 10'h010);
    tv[15] = mk(10'h000, 10'h3FF, 10'h3FF, 0, 0, 1, 0, 7, 10'h010);
    tv[16] = mk(10'h010, 10'h3FF, 10'h3FF, 1, 0, 0, 1, 4, 10'h010);
    tv[17] = mk(10'h010, 10'h3FF, 10'h3FF, 0, 0, 0, 1, 4, 10'h010);
    tv[18] = mk(10'h010, 10'h3FF, 10'h3FF, 0, 1, 0, 0, 4, 10'h010);
    tv[19] = mk(10'h000, 10'h3FF, 10'h3FF, 0, 0, 1, 0, 4, 10'h010);
    tv[20] = mk(10'h000, 10'h3FF, 10'h3FF, 1, 0, 0, 1, 4, 10'h000);
    tv[21] = mk(10'h000, 10'h3FF, 10'h3FF, 0, 1, 0, 0, 4, 10'h000);
    tv[22] = mk(10'h020, 10'h3DF, 10'h3FF, 0, 0, 0, 0, 4, 10'h020);
    tv[23] = mk(10'h000, 10'h3DF, 10'h3FF, 0, 0, 0, 0, 4, 10'h020);
    tv[24] = mk(10'h000, 10'h3FF, 10'h3FF, 0, 0, 1, 0, 4, 10'h020);
    tv[25] = mk(10'h000, 10'h3DF, 10'h3FF, 0, 0, 0, 0, 4, 10'h020);
    tv[26] = mk(10'h000, 10'h3DF, 10'h3FF, 1, 0, 0, 0, 4, 10'h020);
    tv[27] = mk(10'h000, 10'h3FF, 10'h3FF, 0, 1, 1, 0, 4, 10'h020);
    tv[28] = mk(10'h000, 10'h3FF, 10'h3FF, 0, 1, 1, 0, 4, 10'h020);
    tv[29] = mk(10'h000, 10'h3FF, 10'h3FF, 1, 1, 0, 1, 5, 10'h000);
    tv[30] = mk(10'h001, 10'h3FF, 10'h3FF, 1, 0, 0, 1, 5, 10'h001);
    tv[31] = mk(10'h001, 10'h3FF, 10'h3FF, 1, 1, 0, 0, 5, 10'h001);
    tv[32] = mk(10'h001, 10'h3FF, 10'h3FF, 0, 0, 1, 0, 5, 10'h001);
    tv[33] = mk(10'h3FF, 10'h3FF, 10'h000, 1, 0, 0, 1, 0, 10'h3FF);

    #2;
    chk("reset_int_out", -1, 32'(bus.int_out), 32'd0);
    chk("reset_int_id_vld", -1, 32'(bus.int_id_vld), 32'd0);
    chk("reset_int_id", -1, 32'(bus.int_id), 32'd0);
    chk("reset_pending", -1, 32'(bus.pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i]);
      @(posedge clk);
      #1;
      compare(i);
    end

    // In SERVICE with pending=3FF: reset lands mid-cycle and must clear outputs before any edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_int_out", 100, 32'(bus.int_out), 32'd0);
    chk("arst_int_id_vld", 100, 32'(bus.int_id_vld), 32'd0);
    chk("arst_int_id", 100, 32'(bus.int_id), 32'd0);
    chk("arst_pending", 100, 32'(bus.pending), 32'd0);
    bus.int_ack = 1'b0; bus.int_eoi = 1'b0;
    bus.int_en = 10'h3FF; bus.int_edge = 10'h3FF; bus.int_in = 10'h001;
    @(posedge clk);
    #1;
    chk("held_rst_pending", 101, 32'(bus.pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_pending", 102, 32'(bus.pending), 32'h001);
    @(posedge clk);
    #1;
    chk("post_rst_int_out", 103, 32'(bus.int_out), 32'd1);
    chk("post_rst_int_id_vld", 103, 32'(bus.int_id_vld), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gic_core.md
Name: gic_core

Overview:
- Interrupt controller core at the responder end of the interrupt interface. It samples N interrupt request lines (int_in), latches them as pending, raises the single interrupt output (int_out), and serves a CPU-side acknowledge / end-of-interrupt handshake.
- Source selection is fixed priority: lowest index wins.
- Per-source enable and per-source trigger mode (edge or level).

Parameters:
- N, 10, number of interrupt sources (2..32).
- ID_W, $clog2(N), width of the claimed interrupt ID.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- int_in  input  N  interrupt request lines; synchronous to clk, no synchronizer inside.
- int_en  input  N  per-source enable; 1 = source may raise int_out.
- int_edge  input  N  per-source trigger mode; 1 = rising-edge, 0 = level-high.
- int_out  output  1  registered interrupt request to the CPU.
- int_ack  input  1  single-cycle claim pulse from the CPU.
- int_id  output  ID_W  index of the claimed source; valid while int_id_vld is high.
- int_id_vld  output  1  high from the cycle after a claim until the cycle after EOI.
- int_eoi  input  1  single-cycle end-of-interrupt pulse.
- pending  output  N  registered pending status, unmasked.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; pending=0; int_in_q=0; int_out=0; int_id=0; int_id_vld=0.
  - Because int_in_q=0, an edge-mode line already high when reset releases counts as a rising edge on the first sampled cycle.
- Edge detect: rise = int_in & ~int_in_q. int_in_q updates every cycle.
- Next-pending, per bit i:
  - Edge mode: set on rise[i]. Cleared only when source i is claimed. Set wins over clear in the same cycle, so the bit stays 1.
  - Level mode: equals int_in[i]. Never latched. A claim does not clear it.
- Enable:
  - qual = next_pending & int_en.
  - Clearing int_en[i] masks the bit but does not clear pending[i].
- FSM states: IDLE, ASSERT, SERVICE. Transitions are evaluated on each posedge using next-pending and qual.
  - IDLE: if |qual, go to ASSERT and set int_out=1. This gives one-cycle latency: int_in sampled high at edge k produces int_out=1 after edge k+1 (the |int_in |=> int_out rule).
  - ASSERT with |qual==0 (level dropped or enable cleared before claim): go to IDLE, int_out=0. No ID is produced.
  - ASSERT with int_ack=1 and |qual==1:
    - int_id = lowest set index of qual at that edge;
    - int_id_vld=1, int_out=0;
    - clear that pending bit if the source is edge mode;
    - go to SERVICE.
  - SERVICE:
    - int_out stays 0, even if new sources become pending.
    - int_id is held stable.
    - int_ack is ignored.
  - SERVICE with int_eoi=1: go to IDLE, int_id_vld=0. int_id keeps its last value.
    - If qual is still non-zero, the IDLE→ASSERT re-entry happens on the following edge.
    - So int_out is low for at least one cycle between services.
- Ignored inputs: int_ack in IDLE or SERVICE, and int_eoi in IDLE or ASSERT. Neither has any side effect.
- Simultaneous int_ack and int_eoi: only the pulse meaningful in the current state acts.
- Nesting/preemption: none. A higher-priority arrival during SERVICE waits for EOI.
- Reset mid-operation (any state): immediate return to reset values. An in-service claim is lost.

Test Plan:
- Level raise/claim/EOI, N=10:
  - Stimulus: int_en=all 1s, int_edge=0, int_in=10'h008 sampled at edge k.
  - Required: int_out=1 after edge k+1.
  - ack → int_id=3, int_id_vld=1, int_out=0.
  - eoi with int_in still high → int_id_vld=0, int_out re-asserts 2 edges after eoi.
- Priority:
  - Stimulus: edge mode, int_in rises on bits 7 and 2 in the same cycle, then ack.
  - Required: int_id=2; pending=10'h080 after claim.
  - eoi → int_out=1 again, next ack gives int_id=7, then pending=0.
- Edge set/clear collision:
  - Stimulus: bit 4 edge mode and claimed at edge k while int_in[4] makes a new 0→1 transition sampled at the same edge k.
  - Required: pending[4]=1 after claim; source 4 is serviced again after eoi.
- Masking:
  - Stimulus: int_en[5]=0, edge on bit 5.
  - Required: pending[5]=1, int_out stays 0.
  - Set int_en[5]=1 → int_out=1 one edge later. Clear int_en[5] while in ASSERT → int_out=0 next edge, state IDLE.
- Ignored handshakes:
  - Stimulus: int_ack in IDLE; int_eoi in ASSERT; int_ack in SERVICE.
  - Required: no change to int_id, int_id_vld, pending, int_out.
- Async reset:
  - Stimulus: assert rst mid-cycle while in SERVICE with pending=10'h3FF.
  - Required: before the next clock edge, all outputs are 0.
  - Release rst with edge-mode int_in[0]=1 → pending[0]=1 after first edge, int_out=1 after the second edge.
